// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiters.
// Optional build macro RR_ARB_LOCK_EN is consumed by rr_reg_arbiter, not here.
package rr_arb_pkg;

  localparam int MAX_NREQ = 16;
  localparam int PTR_W    = $clog2(MAX_NREQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Modulo-n increment by compare, so non-power-of-two n wraps correctly.
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr, input int n);
    if (int'(ptr) >= n - 1) return '0;
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/mod_register.sv
// Enable-loaded register with asynchronous active-high clear.
// Shared holding-register primitive used by the arbiter.
module mod_register #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     out <= '0;
    else if (en) out <= in;
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// modulo NREQ. Reused by other arbiters.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  pick,
  output logic            any_valid
);

  int             idx;
  logic [IDW-1:0] idx_w;

  // Scan from the farthest offset down so the nearest valid one wins.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = idx[IDW-1:0];
      if (req_valid[idx_w]) begin
        pick      = idx_w;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding one single-entry holding register (mod_register).
// Define RR_ARB_LOCK_EN to add req_lock: a locked beat keeps the grant on its requester.
//
// Handshake: a beat moves on a port when valid & ready are both high at the
// rising clk edge; valid/data are held by the source until that edge.
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  input  logic                  out_ready,
  output state_t                dbg_state,
  output logic [IDW-1:0]        dbg_ptr
);

  state_t         state_q, state_n;
  logic [IDW-1:0] ptr_q, ptr_n, ptr_adv;
  logic [IDW-1:0] rr_idx, pick;
  logic           rr_any, any_sel, load_ok, accept;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .pick      (rr_idx),
    .any_valid (rr_any)
  );

`ifdef RR_ARB_LOCK_EN
  logic           lock_q, lock_n;
  logic [IDW-1:0] lock_id_q, lock_id_n;
`endif

  always_comb begin
    pick    = rr_idx;
    any_sel = rr_any;
`ifdef RR_ARB_LOCK_EN
    // While locked only the lock owner may be picked, even if it is idle.
    if (lock_q) begin
      pick    = lock_id_q;
      any_sel = req_valid[lock_id_q];
    end
`endif
  end

  assign load_ok  = (state_q == EMPTY) | out_ready;
  assign accept   = any_sel & load_ok & ~rst;
  assign sel_data = req_data[pick*WIDTH +: WIDTH];
  assign ptr_adv  = IDW'(rr_next(PTR_W'(pick), NREQ));

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick] = 1'b1;
  end

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    case (state_q)
      EMPTY: if (accept) state_n = FULL;
      FULL: begin
        if (accept)         state_n = FULL;
        else if (out_ready) state_n = EMPTY;
      end
      default: state_n = EMPTY;
    endcase
    if (accept) ptr_n = ptr_adv;
`ifdef RR_ARB_LOCK_EN
    if (accept && req_lock[pick]) ptr_n = ptr_q;
`endif
  end

`ifdef RR_ARB_LOCK_EN
  always_comb begin
    lock_n    = lock_q;
    lock_id_n = lock_id_q;
    if (accept) begin
      lock_n    = req_lock[pick];
      lock_id_n = pick;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_n;
      lock_id_q <= lock_id_n;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
    end
  end

  mod_register #(.W(WIDTH)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .in  (sel_data),
    .out (out_data)
  );

  mod_register #(.W(IDW)) u_id_reg (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .in  (pick),
    .out (out_id)
  );

  assign out_valid = (state_q == FULL);
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule
